button_select_ctrl: RTL
=======================

# button_select_ctrl

Front-end control stage for the board's nibble mux/demux datapath. It synchronizes and debounces the five push buttons (btnL, btnU, btnD, btnR, btnC) and turns clean presses into registered state:

- a 2-bit mux select,
- a 2-bit demux select,
- a demux enable.

The select and enable outputs drive the select/enable inputs of the mux/demux stage directly downstream. Each select is held stable between presses rather than following raw button levels.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, default $clog2(DEBOUNCE_CYCLES+1): debounce counter width.

Ports:
- clk  in  1  system clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset. Deassertion is synchronous to clk externally.
- btnL  in  1  raw button. Press decrements mux_sel.
- btnU  in  1  raw button. Press increments mux_sel.
- btnD  in  1  raw button. Press decrements demux_sel.
- btnR  in  1  raw button. Press increments demux_sel.
- btnC  in  1  raw button. Press toggles enable.
- mux_sel  out  2  registered mux select.
- demux_sel  out  2  registered demux select.
- enable  out  1  registered demux enable.
- btn_level  out  5  debounced levels, ordered {btnC, btnR, btnD, btnU, btnL}.

## Operation
Per-button pipeline (five identical, independent channels):
- **Synchronizer:** 2-flop synchronizer, raw to s1 to s2.
- **Debouncer:** a stable level register plus a CNT_W counter.
  - If s2 equals the stable level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, the stable level takes s2 and the counter clears.
- **Press event:** a one-cycle pulse when the stable level goes 0 to 1. Releases generate no event.

Select/enable logic, registered:
- mux_sel: +1 on a U event, -1 on an L event, modulo 4. Wrap-around: 3+1 gives 0, 0-1 gives 3.
- demux_sel: +1 on an R event, -1 on a D event, modulo 4, same wrap rule.
- enable: inverts on each C event.
- Simultaneous U and L events in the same cycle: mux_sel unchanged. D and R likewise for demux_sel.
- Events on different axes in the same cycle all take effect together.

Held button: one event per press, no auto-repeat.

## Timing
Reset (rst_n low, asynchronous):
- mux_sel=0, demux_sel=0, enable=0, btn_level=0.
- All synchronizer flops, counters and stable levels are 0.

Latency:
- Raw input changes before edge E0; s2 reflects it after edge E1.
- The stable level (btn_level) flips at edge E1+DEBOUNCE_CYCLES, provided s2 holds the new value through those DEBOUNCE_CYCLES consecutive sampled cycles.
- mux_sel, demux_sel and enable update at edge E2+DEBOUNCE_CYCLES.
- Total: 2+DEBOUNCE_CYCLES edges from input to select change.

Glitch rejection:
- Any s2 pulse shorter than DEBOUNCE_CYCLES cycles is ignored and the counter returns to 0.
- A bounce mid-count restarts the count.

Reset mid-debounce:
- The partial count is discarded and no event is produced.
- A button held through reset deassertion is seen as a new press once debounced, because the stable level restarts at 0.

Outputs change only on clock edges, except the asynchronous reset. No combinational path runs from any input to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.

1. **Reset values:** assert rst_n=0 mid-cycle, all buttons 0 → mux_sel=0, demux_sel=0, enable=0, btn_level=0 immediately, without waiting for a clock edge.
2. **Increment with wrap:** hold btnU=1 for 10 cycles, then 0 for 10 cycles, repeated 4 times → mux_sel goes 1,2,3,0. Each update occurs exactly 6 edges after btnU rises. Held btnU causes no extra steps.
3. **Decrement wrap and enable toggle:** one btnD press from reset → demux_sel=3. Two btnC presses → enable goes 1, then 0.
4. **Bounce rejection:** btnR toggles 1,0,1,0 at 1-cycle intervals, then stays 0 → demux_sel unchanged and btn_level[3] stays 0. Next, btnR held high for 3 cycles only → no change. Finally, btnR held 6 cycles → demux_sel increments once.
5. **Simultaneous events:**
   - btnL and btnU rise on the same edge and are held 10 cycles → mux_sel unchanged.
   - btnU and btnR rise together → mux_sel+1 and demux_sel+1 on the same edge.
6. **Reset mid-debounce:** btnC high for 3 cycles, pulse rst_n low, btnC held high afterwards → enable=0 during reset. enable becomes 1 at edge 6 after rst_n deasserts.

Source files
------------

// File: rtl/button_select_if.sv
// Button inputs and select/enable outputs between the board buttons and the
// mux/demux select stage.
interface button_select_if;
    logic       btnL;
    logic       btnU;
    logic       btnD;
    logic       btnR;
    logic       btnC;
    logic [1:0] mux_sel;
    logic [1:0] demux_sel;
    logic       enable;
    logic [4:0] btn_level;

    modport master (
        output btnL, btnU, btnD, btnR, btnC,
        input  mux_sel, demux_sel, enable, btn_level
    );

    modport slave (
        input  btnL, btnU, btnD, btnR, btnC,
        output mux_sel, demux_sel, enable, btn_level
    );
endinterface

// File: rtl/button_select_ctrl.sv
// Synchronizes and debounces five push buttons and turns clean presses into
// registered mux/demux selects and a demux enable.
module button_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic            clk,
    input logic            rst_n,
    button_select_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere: {C, R, D, U, L}
    logic [4:0]       raw;
    logic [4:0]       sync_p0;
    logic [4:0]       sync_p1;
    logic [4:0]       level_p2;
    logic [CNT_W-1:0] cnt_p2 [5];
    logic [4:0]       level_p3;
    logic [4:0]       press;
    logic [1:0]       mux_sel;
    logic [1:0]       demux_sel;
    logic             enable;

    // Modulo-4 step; opposing presses in the same cycle cancel.
    function automatic logic [1:0] step_sel(input logic [1:0] sel,
                                            input logic       up,
                                            input logic       dn);
        if (up && !dn)
            return sel + 2'd1;
        else if (dn && !up)
            return sel - 2'd1;
        else
            return sel;
    endfunction

    assign raw = {bus.btnC, bus.btnR, bus.btnD, bus.btnU, bus.btnL};

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: debounced level, accepted after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_p2 <= '0;
            for (int i = 0; i < 5; i++) cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync_p1[i] == level_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    level_p2[i] <= sync_p1[i];
                    cnt_p2[i]   <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stage p3: previous level for rising-edge (press) detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_p3 <= '0;
        else        level_p3 <= level_p2;
    end

    assign press = level_p2 & ~level_p3;

    // Stage p3: select/enable state driven by press events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_sel   <= 2'd0;
            demux_sel <= 2'd0;
            enable    <= 1'b0;
        end else begin
            mux_sel   <= step_sel(mux_sel, press[1], press[0]);
            demux_sel <= step_sel(demux_sel, press[3], press[2]);
            enable    <= enable ^ press[4];
        end
    end

    assign bus.mux_sel   = mux_sel;
    assign bus.demux_sel = demux_sel;
    assign bus.enable    = enable;
    assign bus.btn_level = level_p2;

endmodule
